// File: rtl/dma_pkg.sv
// Shared constants and FSM state encoding for the DMA address generation unit.
package dma_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DIM_W_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    FIN  = 2'd2
  } agu_state_e;

endpackage

// File: rtl/dmar_agu_if.sv
// Control/status bundle between the AGU and whatever drives its walk.
interface dmar_agu_if import dma_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) ();

  logic              load;
  logic [ADDR_W-1:0] data_in;
  logic              start;
  logic [DIM_W-1:0]  img_w;
  logic [DIM_W-1:0]  img_h;
  logic [DIM_W-1:0]  stride;
  logic              step;
  logic [ADDR_W-1:0] data_out;
  logic [DIM_W-1:0]  col_out;
  logic [DIM_W-1:0]  row_out;
  logic              busy;
  logic              eol;
  logic              done;

  modport master (
    output load, data_in, start, img_w, img_h, stride, step,
    input  data_out, col_out, row_out, busy, eol, done
  );

  modport slave (
    input  load, data_in, start, img_w, img_h, stride, step,
    output data_out, col_out, row_out, busy, eol, done
  );

endinterface

// File: rtl/dmar_agu.sv
// 2D downsampling address generator: walks an image row by row from a base
// address, visiting every stride-th pixel in both axes, one sample per step.
module dmar_agu import dma_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic      clk,
  input  logic      RST_N,
  dmar_agu_if.slave bus
);

  agu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
  logic [ADDR_W-1:0] row_step_q, row_step_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  img_w_q, img_w_d;
  logic [DIM_W-1:0]  img_h_q, img_h_d;
  logic [DIM_W-1:0]  stride_q, stride_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DIM_W:0]     col_nxt, row_nxt;
  logic               col_end, row_end;
  logic [DIM_W-1:0]   stride_in;
  logic [2*DIM_W-1:0] row_step_full;
  logic [ADDR_W-1:0]  row_ptr_nxt;

  // Lookahead coordinates one bit wider than the fields so the compares never overflow
  always_comb begin
    col_nxt       = {1'b0, col_q} + {1'b0, stride_q};
    row_nxt       = {1'b0, row_q} + {1'b0, stride_q};
    col_end       = (col_nxt >= {1'b0, img_w_q});
    row_end       = (row_nxt >= {1'b0, img_h_q});
    stride_in     = (bus.stride == '0) ? DIM_W'(1) : bus.stride;
    row_step_full = (2*DIM_W)'(stride_in) * (2*DIM_W)'(bus.img_w);
    row_ptr_nxt   = row_ptr_q + row_step_q;
  end

  // Next-state logic: load beats start beats step; step only acts during a walk
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    row_ptr_d  = row_ptr_q;
    row_step_d = row_step_q;
    col_d      = col_q;
    row_d      = row_q;
    img_w_d    = img_w_q;
    img_h_d    = img_h_q;
    stride_d   = stride_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (bus.load) begin
      base_d  = bus.data_in;
      addr_d  = bus.data_in;
      col_d   = '0;
      row_d   = '0;
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (bus.start) begin
      img_w_d    = bus.img_w;
      img_h_d    = bus.img_h;
      stride_d   = stride_in;
      row_step_d = ADDR_W'(row_step_full);
      addr_d     = base_q;
      row_ptr_d  = base_q;
      col_d      = '0;
      row_d      = '0;
      if ((bus.img_w == '0) || (bus.img_h == '0)) begin
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = WALK;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        WALK: begin
          if (bus.step) begin
            if (!col_end) begin
              col_d  = col_nxt[DIM_W-1:0];
              addr_d = addr_q + ADDR_W'(stride_q);
            end else if (!row_end) begin
              col_d     = '0;
              row_d     = row_nxt[DIM_W-1:0];
              row_ptr_d = row_ptr_nxt;
              addr_d    = row_ptr_nxt;
            end else begin
              state_d = FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      row_ptr_q  <= '0;
      row_step_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      img_w_q    <= '0;
      img_h_q    <= '0;
      stride_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      row_ptr_q  <= row_ptr_d;
      row_step_q <= row_step_d;
      col_q      <= col_d;
      row_q      <= row_d;
      img_w_q    <= img_w_d;
      img_h_q    <= img_h_d;
      stride_q   <= stride_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out = addr_q;
  assign bus.col_out  = col_q;
  assign bus.row_out  = row_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.eol      = (state_q == WALK) && col_end;

endmodule

// File: tb/tb_dmar_agu.sv
// Scoreboard bench for dmar_agu: a sample-list model predicts every cycle's
// outputs, a negedge monitor compares them, directed sequences add fixed checks.
module tb_dmar_agu;

  localparam int AW = 19;
  localparam int DW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] col;
    logic [DW-1:0] row;
    logic          busy;
    logic          eol;
    logic          done;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] col;
    logic [DW-1:0] row;
    logic          eol;
  } samp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sbq[$];

  samp_t         m_list[$];
  samp_t         m_cur;
  logic [AW-1:0] m_base;
  logic          m_active;
  int            m_idx;

  dmar_agu_if #(.ADDR_W(AW), .DIM_W(DW)) bus ();

  dmar_agu #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .clk   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_list.delete();
    m_cur    = '{'0, '0, '0, 1'b0};
    m_base   = '0;
    m_active = 1'b0;
    m_idx    = 0;
  endtask

  // Reference: a walk is simply the ordered list of sampled pixels
  task automatic model_step(input logic ld, input logic [AW-1:0] din, input logic st,
                            input logic [DW-1:0] w, input logic [DW-1:0] h,
                            input logic [DW-1:0] s, input logic stp);
    exp_t e;
    logic fin;
    int   ss;
    fin = 1'b0;
    if (ld) begin
      m_base   = din;
      m_cur    = '{din, '0, '0, 1'b0};
      m_active = 1'b0;
    end else if (st) begin
      ss = (s == 0) ? 1 : int'(s);
      m_list.delete();
      for (int r = 0; r < int'(h); r += ss) begin
        for (int c = 0; c < int'(w); c += ss) begin
          samp_t  t;
          longint a;
          a      = longint'(m_base) + longint'(r) * longint'(w) + longint'(c);
          t.addr = AW'(a);
          t.col  = DW'(c);
          t.row  = DW'(r);
          t.eol  = (c + ss >= int'(w));
          m_list.push_back(t);
        end
      end
      if (m_list.size() == 0) begin
        m_active = 1'b0;
        m_cur    = '{m_base, '0, '0, 1'b0};
        fin      = 1'b1;
      end else begin
        m_active = 1'b1;
        m_idx    = 0;
        m_cur    = m_list[0];
      end
    end else if (m_active && stp) begin
      if (m_idx + 1 < m_list.size()) begin
        m_idx = m_idx + 1;
        m_cur = m_list[m_idx];
      end else begin
        m_active = 1'b0;
        fin      = 1'b1;
      end
    end
    e.addr = m_cur.addr;
    e.col  = m_cur.col;
    e.row  = m_cur.row;
    e.busy = m_active;
    e.eol  = m_active && m_cur.eol;
    e.done = fin;
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs; returns just after the following falling edge
  task automatic cyc(input logic ld, input logic [AW-1:0] din, input logic st,
                     input logic [DW-1:0] w, input logic [DW-1:0] h,
                     input logic [DW-1:0] s, input logic stp);
    bus.load    = ld;
    bus.data_in = din;
    bus.start   = st;
    bus.img_w   = w;
    bus.img_h   = h;
    bus.stride  = s;
    bus.step    = stp;
    @(posedge clk);
    model_step(ld, din, st, w, h, s, stp);
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.start   = 1'b0;
    bus.img_w   = '0;
    bus.img_h   = '0;
    bus.stride  = '0;
    bus.step    = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " data_out"}, 32'(bus.data_out), 0);
    chk({nm, " col"},      32'(bus.col_out),  0);
    chk({nm, " row"},      32'(bus.row_out),  0);
    chk({nm, " busy"},     32'(bus.busy),     0);
    chk({nm, " eol"},      32'(bus.eol),      0);
    chk({nm, " done"},     32'(bus.done),     0);
  endtask

  // Monitor: every cycle the outputs must match the oldest prediction
  always @(negedge clk) begin
    if (sbq.size() > 0) begin : mon
      exp_t e;
      e = sbq.pop_front();
      n_checks++;
      if ({bus.data_out, bus.col_out, bus.row_out, bus.busy, bus.eol, bus.done} !==
          {e.addr, e.col, e.row, e.busy, e.eol, e.done}) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got addr=%h col=%0d row=%0d busy=%b eol=%b done=%b, expected addr=%h col=%0d row=%0d busy=%b eol=%b done=%b",
                 $time, bus.data_out, bus.col_out, bus.row_out, bus.busy, bus.eol, bus.done,
                 e.addr, e.col, e.row, e.busy, e.eol, e.done);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_in();
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 4x4 image, stride 2
    cyc(1, 19'h01000, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 4, 4, 2, 0);
    chk("s2 first addr", 32'(bus.data_out), 32'h01000);
    chk("s2 first eol",  32'(bus.eol), 0);
    chk("s2 busy",       32'(bus.busy), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s2 addr1", 32'(bus.data_out), 32'h01002);
    chk("s2 eol1",  32'(bus.eol), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s2 addr2", 32'(bus.data_out), 32'h01008);
    chk("s2 row2",  32'(bus.row_out), 2);
    chk("s2 eol2",  32'(bus.eol), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s2 addr3", 32'(bus.data_out), 32'h0100A);
    chk("s2 eol3",  32'(bus.eol), 1);
    chk("s2 no early done", 32'(bus.done), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s2 done",      32'(bus.done), 1);
    chk("s2 busy end",  32'(bus.busy), 0);
    chk("s2 addr hold", 32'(bus.data_out), 32'h0100A);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s2 done one cycle", 32'(bus.done), 0);

    // Address wrap across the top of memory
    cyc(1, 19'h7FFFE, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8, 1, 1, 0);
    chk("wrap base", 32'(bus.data_out), 32'h7FFFE);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap a1", 32'(bus.data_out), 32'h7FFFF);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap a2", 32'(bus.data_out), 32'h00000);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap a3", 32'(bus.data_out), 32'h00001);

    // Load overrides step mid-walk
    cyc(1, 19'h12345, 0, 0, 0, 0, 1);
    chk("load abort addr", 32'(bus.data_out), 32'h12345);
    chk("load abort busy", 32'(bus.busy), 0);
    chk("load abort done", 32'(bus.done), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("idle step addr", 32'(bus.data_out), 32'h12345);

    // Empty image finishes immediately; steps afterwards do nothing
    cyc(0, 0, 1, 5, 0, 1, 0);
    chk("empty done", 32'(bus.done), 1);
    chk("empty busy", 32'(bus.busy), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("empty done pulse", 32'(bus.done), 0);
    chk("empty busy later", 32'(bus.busy), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("idle hold addr", 32'(bus.data_out), 32'h12345);

    // Stride 0 behaves as stride 1
    cyc(1, 19'h00200, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 1, 0, 0);
    chk("s0 a0", 32'(bus.data_out), 32'h00200);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s0 a1", 32'(bus.data_out), 32'h00201);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s0 a2", 32'(bus.data_out), 32'h00202);
    chk("s0 eol", 32'(bus.eol), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s0 done", 32'(bus.done), 1);

    // Asynchronous reset in the middle of a walk
    cyc(1, 19'h00300, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 6, 6, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("pre-reset busy", 32'(bus.busy), 1);
    idle_in();
    bus.step = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    @(posedge clk);
    #1 chk_all_zero("reset held");
    #2 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("post-reset step ignored", 32'(bus.data_out), 0);
    chk("post-reset no done", 32'(bus.done), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic          ld, st, stp;
      logic [AW-1:0] din;
      ld  = ($urandom_range(0, 99) < 3);
      st  = ($urandom_range(0, 99) < 5);
      stp = ($urandom_range(0, 99) < 75);
      din = ($urandom_range(0, 3) == 0) ? AW'(19'h7FFF0 + $urandom_range(0, 15))
                                        : AW'($urandom);
      cyc(ld, din, st, DW'($urandom_range(0, 9)), DW'($urandom_range(0, 6)),
          DW'($urandom_range(0, 4)), stp);
    end

    idle_in();
    @(negedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmar_agu.md
DMAR_AGU -- requirements
Module: dmar_agu

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, data memory address width.
REQ-002 SHALL have parameter DIM_W, default 10, width of image dimension, stride and coordinate fields.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1  load data_in as walk base address and as data_out.
REQ-006 SHALL have port data_in  input  ADDR_W  base address.
REQ-007 SHALL have port start  input  1  begin a 2D downsampling walk from the base address.
REQ-008 SHALL have port img_w, img_h  input  DIM_W each  image width and height in pixels, sampled at start.
REQ-009 SHALL have port stride  input  DIM_W  sampling step in both axes, sampled at start.
REQ-010 SHALL have port step  input  1  advance to the next sample address.
REQ-011 SHALL have port data_out  output  ADDR_W  current memory address (registered).
REQ-012 SHALL have ports col_out, row_out  output  DIM_W each  current pixel coordinates (registered).
REQ-013 SHALL have ports busy, eol, done  output  1 each  walk active; current address is last in its row; one-cycle walk-complete pulse.

Function
REQ-014 SHALL implement FSM states IDLE, WALK, FIN; IDLE after reset.
REQ-015 SHALL apply priority load > start > step when asserted in the same cycle.
REQ-016 SHALL, on load in any state: base <= data_in, data_out <= data_in, col/row <= 0, state <= IDLE, busy <= 0, no done pulse (aborts walk).
REQ-017 SHALL, on start (any state, no load): latch img_w, img_h, stride (stride 0 treated as 1); row_step <= stride*img_w; data_out <= base; col/row <= 0; state <= WALK; busy <= 1.
REQ-018 SHALL, on start with img_w==0 or img_h==0: enter FIN directly, pulse done next cycle, data_out <= base.
REQ-019 SHALL, on step in WALK with col+stride < img_w: col += stride, data_out += stride.
REQ-020 SHALL, on step in WALK at row end with row+stride < img_h: col <= 0, row += stride, row_ptr += row_step, data_out <= new row_ptr.
REQ-021 SHALL, on step in WALK at final sample: hold data_out/col/row, state <= FIN, busy <= 0.
REQ-022 SHALL, in FIN, assert done for exactly one cycle and return to IDLE next cycle unless start/load.
REQ-023 SHALL ignore step in IDLE and FIN (all outputs hold).
REQ-024 SHALL compute eol combinationally from registered state: WALK and col+stride >= img_w.
REQ-025 SHALL perform address arithmetic modulo 2^ADDR_W (silent wrap); coordinate compares in DIM_W+1 bits (no overflow).
REQ-026 SHALL make step latency one cycle: address for step N visible on data_out the cycle after step sampled.

Reset
REQ-027 SHALL, while RST_N low: data_out, base, row_ptr, row_step, col_out, row_out <= 0; busy, done <= 0; state <= IDLE, regardless of clk.
REQ-028 SHALL resume on the first rising clk edge after RST_N deassertion; reset mid-walk discards the walk, no done pulse.

Structure
REQ-029 SHALL place FSM state encoding and default ADDR_W/DIM_W constants in shared package dma_pkg.
REQ-030 SHALL be a single module; optional sub-module dmar_coord_ctr (col/row stride counter with end flags) permitted.

Verification
REQ-031 SHALL check: RST_N low mid-walk -> all outputs 0, state IDLE, no done.
REQ-032 SHALL check: load 0x01000, start img_w=4 img_h=4 stride=2, step x4 -> data_out 0x01000, 0x01002, 0x01008, 0x0100A, done pulse after 4th step, eol high at 0x01002/0x0100A.
REQ-033 SHALL check: base 0x7FFFE, img_w=8 img_h=1 stride=1, 3 steps -> data_out 0x7FFFF, 0x00000, 0x00001 (wrap).
REQ-034 SHALL check: load and step in same WALK cycle -> data_out = data_in, state IDLE, busy 0.
REQ-035 SHALL check: start with img_h=0 -> done pulse 1 cycle later, busy never 1; step in IDLE -> outputs unchanged.
REQ-036 SHALL check: stride=0, img_w=3 img_h=1 -> behaves as stride 1, addresses base, base+1, base+2, then done.
